// File: rtl/div_multi.sv
// rtl/div_multi.sv - multi-channel pulse divider with register readback
// Optional per-channel enable inputs when DIV_ENABLE_EN is defined.
module div_multi #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [NUM_CH-1:0] inp_i,
    input  logic [NUM_CH-1:0] rst_i,
`ifdef DIV_ENABLE_EN
    input  logic [NUM_CH-1:0] ena_i,
`endif
    output logic [NUM_CH-1:0] outd_o,
    output logic [NUM_CH-1:0] outn_o,
    input  logic              reg_wr_i,
    input  logic              reg_rd_i,
    input  logic [5:0]        reg_addr_i,
    input  logic [31:0]       reg_wdata_i,
    output logic [31:0]       reg_rdata_o,
    output logic              reg_rvalid_o
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0]  cnt_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_d [NUM_CH];
    logic [CNT_W-1:0]  div_q [NUM_CH];
    logic [CNT_W-1:0]  div_d [NUM_CH];
    logic [NUM_CH-1:0] first_q, first_d;
    logic [NUM_CH-1:0] inp_q, rsti_q;
    logic [NUM_CH-1:0] outd_q, outd_d, outn_q, outn_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              rvalid_q;
    logic [NUM_CH-1:0] en_w, ena_rise;

`ifdef DIV_ENABLE_EN
    logic [NUM_CH-1:0] ena_q;
    assign en_w     = ena_i;
    assign ena_rise = ena_i & ~ena_q;
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) ena_q <= '0;
        else         ena_q <= ena_i;
    end
`else
    assign en_w     = '1;
    assign ena_rise = '0;
`endif

    always_comb begin
        logic [CNT_W-1:0] eff_m1;
        logic [CNT_W-1:0] reload_val;
        logic             hit;
        logic             reload;
        outd_d  = '0;
        outn_d  = '0;
        first_d = first_q;
        rdata_d = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            hit      = (int'(reg_addr_i[5:2]) == c);
            div_d[c] = div_q[c];
            if (reg_wr_i && hit && reg_addr_i[1:0] == 2'd0) div_d[c] = reg_wdata_i[CNT_W-1:0];
            if (reg_wr_i && hit && reg_addr_i[1:0] == 2'd1) first_d[c] = reg_wdata_i[0];
            // Reload target follows the configuration being written this cycle.
            eff_m1     = (div_d[c] == '0) ? '0 : div_d[c] - ONE;
            reload_val = first_d[c] ? eff_m1 : '0;
            reload     = (rst_i[c] & ~rsti_q[c]) | ena_rise[c]
                       | (reg_wr_i & hit & (reg_addr_i[1:0] != 2'd3));
            cnt_d[c] = cnt_q[c];
            if (reload || !en_w[c]) begin
                cnt_d[c] = reload_val;
            end else if (inp_i[c] && !inp_q[c]) begin
                if (cnt_q[c] == eff_m1) begin
                    outd_d[c] = 1'b1;
                    cnt_d[c]  = '0;
                end else begin
                    outn_d[c] = 1'b1;
                    cnt_d[c]  = cnt_q[c] + ONE;
                end
            end
            if (reg_rd_i && hit) begin
                case (reg_addr_i[1:0])
                    2'd0:    rdata_d = 32'(div_q[c]);
                    2'd1:    rdata_d = 32'(first_q[c]);
                    2'd3:    rdata_d = 32'(cnt_d[c]);
                    default: rdata_d = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int c = 0; c < NUM_CH; c++) begin
                cnt_q[c] <= '0;
                div_q[c] <= ONE;
            end
            first_q  <= '0;
            inp_q    <= '0;
            rsti_q   <= '0;
            outd_q   <= '0;
            outn_q   <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                cnt_q[c] <= cnt_d[c];
                div_q[c] <= div_d[c];
            end
            first_q  <= first_d;
            inp_q    <= inp_i;
            rsti_q   <= rst_i;
            outd_q   <= outd_d;
            outn_q   <= outn_d;
            rdata_q  <= rdata_d;
            rvalid_q <= reg_rd_i;
        end
    end

    assign outd_o       = outd_q;
    assign outn_o       = outn_q;
    assign reg_rdata_o  = rdata_q;
    assign reg_rvalid_o = rvalid_q;

endmodule
